mpu_reg_port_arbiter: RTL

//  Shares the matrix register file's single write port (load unit vs. result collector) and single

---
 rtl/mpu_reg_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mpu_reg_port_arbiter.sv
// mpu_reg_port_arbiter
// Arbitrates the matrix register file's single write port (load unit vs.
// result collector) and single read port (store unit vs. multiply
// dispatcher). Each port has a round-robin FSM that holds a grant for the
// whole transaction. A read-after-write address hazard check gates new read
// grants. A hold-time watchdog forces a release when an owner keeps its
// request high for too long.
module mpu_reg_port_arbiter #(
    parameter int ADDR_W   = 3,
    parameter int MAX_HOLD = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_load_req,
    input  logic [ADDR_W-1:0] reg_load_addr,
    input  logic              reg_collector_req,
    input  logic [ADDR_W-1:0] reg_dest_addr,
    input  logic              reg_store_req,
    input  logic [ADDR_W-1:0] reg_store_addr,
    input  logic              reg_disp_req,
    input  logic [ADDR_W-1:0] reg_src_addr_0,
    input  logic [ADDR_W-1:0] reg_src_addr_1,
    output logic              reg_load_gnt,
    output logic              reg_collector_gnt,
    output logic              reg_store_gnt,
    output logic              reg_disp_gnt,
    output logic              wr_sel,
    output logic              rd_sel,
    output logic              arb_timeout
);

    // Hold counter wide enough to reach MAX_HOLD. A MAX_HOLD of 0 turns the watchdog off.
    localparam int              CNT_W   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic            WD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_LOAD = 2'd1,
        W_COLL = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_STORE = 2'd1,
        R_DISP  = 2'd2
    } r_state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic              w_last_coll_q;   // 1: collector served last, so load is favoured next
    logic              r_last_disp_q;   // 1: dispatcher served last, so store is favoured next
    logic [CNT_W-1:0]  w_cnt_q;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              load_lock_q, coll_lock_q, store_lock_q, disp_lock_q;
    logic              load_gnt_q, coll_gnt_q, store_gnt_q, disp_gnt_q;
    logic              wr_sel_q, rd_sel_q, arb_timeout_q;

    // Combinational eligibility and decisions
    logic load_elig, coll_elig, store_elig, disp_elig;
    logic w_own, store_hazard, disp_hazard;
    logic w_hold_max, r_hold_max;
    logic w_to, r_to;

    // Eligibility: a locked-out requester waits for its request to drop,
    // and a read may not start on a register that the current write owner targets.
    always_comb begin
        w_own        = (w_state_q != W_IDLE);
        store_hazard = w_own && (wr_addr_q == reg_store_addr);
        disp_hazard  = w_own && ((wr_addr_q == reg_src_addr_0) ||
                                 (wr_addr_q == reg_src_addr_1));
        load_elig    = reg_load_req      && !load_lock_q;
        coll_elig    = reg_collector_req && !coll_lock_q;
        store_elig   = reg_store_req     && !store_lock_q && !store_hazard;
        disp_elig    = reg_disp_req      && !disp_lock_q  && !disp_hazard;
        w_hold_max   = WD_EN && (w_cnt_q == MAX_CNT);
        r_hold_max   = WD_EN && (r_cnt_q == MAX_CNT);
    end

    // Write-port next state: round-robin from idle, hold while requested,
    // hand over directly on release, and force a release on watchdog expiry.
    always_comb begin
        w_state_d = w_state_q;
        w_to      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (load_elig && coll_elig) begin
                    w_state_d = w_last_coll_q ? W_LOAD : W_COLL;
                end else if (load_elig) begin
                    w_state_d = W_LOAD;
                end else if (coll_elig) begin
                    w_state_d = W_COLL;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_LOAD: begin
                if (!reg_load_req) begin
                    w_state_d = coll_elig ? W_COLL : W_IDLE;
                end else if (w_hold_max) begin
                    w_to      = 1'b1;
                    w_state_d = coll_elig ? W_COLL : W_IDLE;
                end else begin
                    w_state_d = W_LOAD;
                end
            end
            W_COLL: begin
                if (!reg_collector_req) begin
                    w_state_d = load_elig ? W_LOAD : W_IDLE;
                end else if (w_hold_max) begin
                    w_to      = 1'b1;
                    w_state_d = load_elig ? W_LOAD : W_IDLE;
                end else begin
                    w_state_d = W_COLL;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Read-port next state: same policy as the write port, with hazard-gated eligibility.
    always_comb begin
        r_state_d = r_state_q;
        r_to      = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (store_elig && disp_elig) begin
                    r_state_d = r_last_disp_q ? R_STORE : R_DISP;
                end else if (store_elig) begin
                    r_state_d = R_STORE;
                end else if (disp_elig) begin
                    r_state_d = R_DISP;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_STORE: begin
                if (!reg_store_req) begin
                    r_state_d = disp_elig ? R_DISP : R_IDLE;
                end else if (r_hold_max) begin
                    r_to      = 1'b1;
                    r_state_d = disp_elig ? R_DISP : R_IDLE;
                end else begin
                    r_state_d = R_STORE;
                end
            end
            R_DISP: begin
                if (!reg_disp_req) begin
                    r_state_d = store_elig ? R_STORE : R_IDLE;
                end else if (r_hold_max) begin
                    r_to      = 1'b1;
                    r_state_d = store_elig ? R_STORE : R_IDLE;
                end else begin
                    r_state_d = R_DISP;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Write-port FSM register: state, RR pointer, hold counter, latched address, lockouts and grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q     <= W_IDLE;
            w_last_coll_q <= 1'b1;
            w_cnt_q       <= {CNT_W{1'b0}};
            wr_addr_q     <= {ADDR_W{1'b0}};
            load_lock_q   <= 1'b0;
            coll_lock_q   <= 1'b0;
            load_gnt_q    <= 1'b0;
            coll_gnt_q    <= 1'b0;
            wr_sel_q      <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (w_state_d != w_state_q) begin
                if (w_state_d == W_LOAD) begin
                    w_cnt_q       <= CNT_ONE;
                    wr_addr_q     <= reg_load_addr;
                    w_last_coll_q <= 1'b0;
                end else if (w_state_d == W_COLL) begin
                    w_cnt_q       <= CNT_ONE;
                    wr_addr_q     <= reg_dest_addr;
                    w_last_coll_q <= 1'b1;
                end else begin
                    w_cnt_q <= {CNT_W{1'b0}};
                end
            end else if (WD_EN && w_own && (w_cnt_q != MAX_CNT)) begin
                w_cnt_q <= w_cnt_q + CNT_ONE;
            end else begin
                w_cnt_q <= w_cnt_q;
            end
            if (w_to && (w_state_q == W_LOAD)) begin
                load_lock_q <= 1'b1;
            end else if (!reg_load_req) begin
                load_lock_q <= 1'b0;
            end else begin
                load_lock_q <= load_lock_q;
            end
            if (w_to && (w_state_q == W_COLL)) begin
                coll_lock_q <= 1'b1;
            end else if (!reg_collector_req) begin
                coll_lock_q <= 1'b0;
            end else begin
                coll_lock_q <= coll_lock_q;
            end
            load_gnt_q <= (w_state_d == W_LOAD);
            coll_gnt_q <= (w_state_d == W_COLL);
            wr_sel_q   <= (w_state_d == W_COLL);
        end
    end

    // Read-port FSM register: state, RR pointer, hold counter, lockouts and grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= R_IDLE;
            r_last_disp_q <= 1'b1;
            r_cnt_q       <= {CNT_W{1'b0}};
            store_lock_q  <= 1'b0;
            disp_lock_q   <= 1'b0;
            store_gnt_q   <= 1'b0;
            disp_gnt_q    <= 1'b0;
            rd_sel_q      <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (r_state_d != r_state_q) begin
                if (r_state_d == R_STORE) begin
                    r_cnt_q       <= CNT_ONE;
                    r_last_disp_q <= 1'b0;
                end else if (r_state_d == R_DISP) begin
                    r_cnt_q       <= CNT_ONE;
                    r_last_disp_q <= 1'b1;
                end else begin
                    r_cnt_q <= {CNT_W{1'b0}};
                end
            end else if (WD_EN && (r_state_q != R_IDLE) && (r_cnt_q != MAX_CNT)) begin
                r_cnt_q <= r_cnt_q + CNT_ONE;
            end else begin
                r_cnt_q <= r_cnt_q;
            end
            if (r_to && (r_state_q == R_STORE)) begin
                store_lock_q <= 1'b1;
            end else if (!reg_store_req) begin
                store_lock_q <= 1'b0;
            end else begin
                store_lock_q <= store_lock_q;
            end
            if (r_to && (r_state_q == R_DISP)) begin
                disp_lock_q <= 1'b1;
            end else if (!reg_disp_req) begin
                disp_lock_q <= 1'b0;
            end else begin
                disp_lock_q <= disp_lock_q;
            end
            store_gnt_q <= (r_state_d == R_STORE);
            disp_gnt_q  <= (r_state_d == R_DISP);
            rd_sel_q    <= (r_state_d == R_DISP);
        end
    end

    // Timeout pulse: one cycle, shared by both ports so simultaneous expiries give a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_timeout_q <= 1'b0;
        end else begin
            arb_timeout_q <= w_to || r_to;
        end
    end

    assign reg_load_gnt      = load_gnt_q;
    assign reg_collector_gnt = coll_gnt_q;
    assign reg_store_gnt     = store_gnt_q;
    assign reg_disp_gnt      = disp_gnt_q;
    assign wr_sel            = wr_sel_q;
    assign rd_sel            = rd_sel_q;
    assign arb_timeout       = arb_timeout_q;

endmodule
